traffic_phase_timer: RTL and testbench
======================================

Name: traffic_phase_timer

Overview:
- Countdown timer paired with the traffic light FSM.
- Consumes the FSM's per-phase load code (light_cnt_init) and returns the one-cycle-aligned last_cnt that advances the FSM.
- Holds programmable green/yellow/red durations, prescales clk to a seconds tick, and drives a BCD remaining-time value for the 7-segment display.

Parameters:
- CLK_DIV, 50000000: clk cycles per count tick (≥2).
- CNT_WIDTH, 7: width of count and duration registers (max value 99).
- GREEN_T, 15: reset value of the green duration.
- YELLOW_T, 3: reset value of the yellow duration.
- RED_T, 18: reset value of the red duration.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  system enable, same signal that drives the FSM
- light_cnt_init  in  3  load code from the FSM: 100 green, 010 yellow, 001 red, 000 no load
- cfg_we  in  1  duration write strobe
- cfg_sel  in  2  0 green, 1 yellow, 2 red, 3 reserved
- cfg_data  in  CNT_WIDTH  duration value in ticks
- last_cnt  out  1  phase expired, to the FSM
- cnt  out  CNT_WIDTH  remaining ticks
- cnt_tens  out  4  BCD tens of cnt
- cnt_ones  out  4  BCD ones of cnt
- tick  out  1  prescaler pulse, one clk wide
- err  out  1  sticky error flag

Behaviour:
- Interface (already decided): reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: state IDLE, cnt 0, prescaler 0, last_cnt 0, tick 0, err 0. Duration registers reset to GREEN_T, YELLOW_T and RED_T.
- States:
  - IDLE: cnt 0, last_cnt 0.
  - RUN: counting down.
  - EXPIRED: cnt 0, last_cnt 1.
- en=0 at a clk edge, from any state: next state IDLE, cnt 0, prescaler 0, last_cnt 0. Durations are retained.
- IDLE with en=1: at the next edge, load cnt=green duration, clear the prescaler, go to RUN. This matches the FSM's IDLE→GREEN step, which carries no load code.
- Load, with en=1, in any state except IDLE:
  - Trigger: light_cnt_init one-hot.
  - Action: cnt ← selected duration, prescaler ← 0, state RUN, last_cnt ← 0.
  - A load takes priority over a tick and over expiry in the same cycle.
  - light_cnt_init with 2 or more bits set: no load, err ← 1.
  - light_cnt_init nonzero in IDLE: ignored; the green load applies.
- RUN:
  - Prescaler counts 0..CLK_DIV-1 and wraps to 0.
  - tick=1 (combinational) when the prescaler equals CLK_DIV-1 in RUN; otherwise tick=0.
  - On tick with cnt>1: cnt decrements by 1.
  - On tick with cnt==1: cnt ← 0, state EXPIRED, last_cnt ← 1 (registered).
- EXPIRED:
  - Prescaler is held at 0.
  - last_cnt stays 1 until a load or en=0.
  - During the last_cnt=1 cycle the FSM presents the next load code, so the next edge reloads. A phase therefore lasts duration×CLK_DIV cycles plus one EXPIRED cycle.
- Duration writes:
  - On cfg_we, the register selected by cfg_sel is updated at the clock edge.
  - cfg_data=0, cfg_data>99, or cfg_sel=3: write rejected, register unchanged, err ← 1.
  - A write never alters the running cnt; it applies at the next load.
  - Write and load of the same register in the same cycle: the load uses the old value.
- err is sticky. Only rst_n clears it.
- BCD outputs are combinational from cnt: cnt_tens=cnt/10, cnt_ones=cnt%10. cnt never exceeds 99.
- Reset asserted mid-phase clears everything asynchronously, including the duration registers, which return to their parameter values.

Test Plan:
All scenarios use CLK_DIV=4. Edge E0 is the first edge with en=1.
- Reset, then en=1 from IDLE with light_cnt_init=000:
  - E0: cnt=15, tick every 4th cycle.
  - cnt=1 after E56.
  - E60: cnt=0, last_cnt=1.
- Green expiry, then drive 010 during the last_cnt cycle:
  - E61: cnt=3, last_cnt=0.
  - E73: last_cnt=1.
  - Drive 001: cnt=18, cnt_tens=1, cnt_ones=8.
- Write cfg_sel=1, cfg_data=5 during green:
  - Green count is unaffected.
  - The next yellow load gives cnt=5 and lasts 20 cycles to last_cnt.
- Rejected writes:
  - cfg_data=0 → err=1, yellow duration unchanged.
  - cfg_data=100 → err=1, duration unchanged.
  - cfg_sel=3 → err=1.
  - Only rst_n clears err.
- Drop en mid-RUN with cnt=9:
  - Next edge: cnt=0, last_cnt=0, tick=0.
  - Re-raise en: cnt=15 (green) one edge later.
- Load code 110 during RUN → no reload, err=1, countdown continues. Load 100 coincident with tick → cnt=green duration, prescaler=0, no decrement.

Source files
------------

// File: rtl/traffic_phase_timer_if.sv
// -----------------------------------------------------------------------------
// traffic_phase_timer_if
// Signal bundle between the traffic light FSM side (master) and the phase
// timer (slave).
//   en              master->slave  system enable
//   light_cnt_init  master->slave  one-hot load code (100 G, 010 Y, 001 R)
//   cfg_we/sel/data master->slave  duration register write port
//   last_cnt        slave->master  phase expired
//   cnt             slave->master  remaining ticks
//   cnt_tens/ones   slave->master  BCD digits of cnt
//   tick            slave->master  prescaler pulse
//   err             slave->master  sticky error flag
// -----------------------------------------------------------------------------
interface traffic_phase_timer_if #(
    parameter int CNT_WIDTH = 7
);
    logic                 en;
    logic [2:0]           light_cnt_init;
    logic                 cfg_we;
    logic [1:0]           cfg_sel;
    logic [CNT_WIDTH-1:0] cfg_data;
    logic                 last_cnt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [3:0]           cnt_tens;
    logic [3:0]           cnt_ones;
    logic                 tick;
    logic                 err;

    modport master (
        output en, light_cnt_init, cfg_we, cfg_sel, cfg_data,
        input  last_cnt, cnt, cnt_tens, cnt_ones, tick, err
    );

    modport slave (
        input  en, light_cnt_init, cfg_we, cfg_sel, cfg_data,
        output last_cnt, cnt, cnt_tens, cnt_ones, tick, err
    );
endinterface

// File: rtl/traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// traffic_phase_timer
// Countdown timer companion of the traffic light FSM. Loads the duration of
// the phase requested by the FSM, prescales clk into count ticks, counts down
// and raises last_cnt for one registered state (EXPIRED) so the FSM advances.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus_if  slave side of traffic_phase_timer_if (control, config, status)
// -----------------------------------------------------------------------------
module traffic_phase_timer #(
    parameter int CLK_DIV   = 50000000,
    parameter int CNT_WIDTH = 7,
    parameter int GREEN_T   = 15,
    parameter int YELLOW_T  = 3,
    parameter int RED_T     = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    traffic_phase_timer_if.slave  bus_if
);
    localparam int PS_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAXV = CNT_WIDTH'(99);
    localparam logic [CNT_WIDTH-1:0] DUR_RST [3] = '{
        CNT_WIDTH'(GREEN_T), CNT_WIDTH'(YELLOW_T), CNT_WIDTH'(RED_T)
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PS_W-1:0]      ps_q, ps_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] dur_q [3];

    logic                 tick_w;
    logic                 code_onehot;
    logic                 code_multi;
    logic                 cfg_ok;
    logic [CNT_WIDTH-1:0] load_val;

    assign tick_w      = (state_q == RUN) && (ps_q == PS_MAX);
    assign code_onehot = (bus_if.light_cnt_init == 3'b100) ||
                         (bus_if.light_cnt_init == 3'b010) ||
                         (bus_if.light_cnt_init == 3'b001);
    assign code_multi  = (bus_if.light_cnt_init != 3'b000) && !code_onehot;
    assign cfg_ok      = (bus_if.cfg_sel != 2'd3) &&
                         (bus_if.cfg_data != '0) &&
                         (bus_if.cfg_data <= CNT_MAXV);

    // Duration lookup uses the registered values, so a write in the same
    // cycle as a load only takes effect at the following load.
    always_comb begin
        load_val = dur_q[0];
        case (bus_if.light_cnt_init)
            3'b010:  load_val = dur_q[1];
            3'b001:  load_val = dur_q[2];
            default: load_val = dur_q[0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ps_d    = ps_q;
        err_d   = err_q;

        if (bus_if.cfg_we && !cfg_ok) begin
            err_d = 1'b1;
        end

        if (!bus_if.en) begin
            state_d = IDLE;
            cnt_d   = '0;
            ps_d    = '0;
        end else begin
            case (state_q)
                // The FSM's IDLE->GREEN step carries no load code, so the
                // green duration is loaded unconditionally here.
                IDLE: begin
                    state_d = RUN;
                    cnt_d   = dur_q[0];
                    ps_d    = '0;
                end
                RUN, EXPIRED: begin
                    if (code_onehot) begin
                        // Load wins over a coincident tick or expiry.
                        state_d = RUN;
                        cnt_d   = load_val;
                        ps_d    = '0;
                    end else begin
                        if (code_multi) begin
                            err_d = 1'b1;
                        end
                        if (state_q == RUN) begin
                            if (tick_w) begin
                                ps_d = '0;
                                if (cnt_q > CNT_WIDTH'(1)) begin
                                    cnt_d = cnt_q - CNT_WIDTH'(1);
                                end else begin
                                    cnt_d   = '0;
                                    state_d = EXPIRED;
                                end
                            end else begin
                                ps_d = ps_q + PS_W'(1);
                            end
                        end else begin
                            ps_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ps_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ps_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ps_q    <= ps_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur_q <= DUR_RST;
        end else if (bus_if.cfg_we && cfg_ok) begin
            for (int i = 0; i < 3; i++) begin
                if (bus_if.cfg_sel == 2'(i)) begin
                    dur_q[i] <= bus_if.cfg_data;
                end
            end
        end
    end

    assign bus_if.last_cnt = (state_q == EXPIRED);
    assign bus_if.cnt      = cnt_q;
    assign bus_if.cnt_tens = 4'(cnt_q / CNT_WIDTH'(10));
    assign bus_if.cnt_ones = 4'(cnt_q % CNT_WIDTH'(10));
    assign bus_if.tick     = tick_w;
    assign bus_if.err      = err_q;
endmodule

// File: tb/tb_traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_timer
// Directed scenarios followed by randomized traffic, checked against a
// reference model that computes the expected outputs from the time elapsed
// since the last load (deadline arithmetic rather than a cycle-level copy).
// -----------------------------------------------------------------------------
module tb_traffic_phase_timer;
    localparam int DIV = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // reference model state
    bit   m_active;
    int   m_load;
    int   m_len;
    int   m_dur [3];
    bit   m_err;

    traffic_phase_timer_if #(.CNT_WIDTH(7)) bus ();

    traffic_phase_timer #(
        .CLK_DIV  (DIV),
        .CNT_WIDTH(7),
        .GREEN_T  (15),
        .YELLOW_T (3),
        .RED_T    (18)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_if(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_load   = 0;
        m_len    = 0;
        m_dur[0] = 15;
        m_dur[1] = 3;
        m_dur[2] = 18;
        m_err    = 0;
    endtask

    task automatic model_edge(input bit e, input logic [2:0] code, input bit we,
                              input logic [1:0] sel, input int data);
        if (!e) begin
            m_active = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_load   = cyc;
            m_len    = m_dur[0];
        end else if (code == 3'b100 || code == 3'b010 || code == 3'b001) begin
            m_load = cyc;
            m_len  = (code == 3'b100) ? m_dur[0] : (code == 3'b010) ? m_dur[1] : m_dur[2];
        end else if (code != 3'b000) begin
            m_err = 1;
        end
        if (we) begin
            if (sel == 2'd3 || data == 0 || data > 99) m_err = 1;
            else m_dur[sel] = data;
        end
    endtask

    task automatic check_all();
        int el, total, e_cnt;
        bit e_last, e_tick;
        el     = cyc - m_load;
        total  = m_len * DIV;
        e_cnt  = (!m_active || el >= total) ? 0 : m_len - el / DIV;
        e_last = m_active && (el >= total);
        e_tick = m_active && (el < total) && (el % DIV == DIV - 1);
        check_val("cnt",      bus.cnt,      e_cnt);
        check_val("last_cnt", bus.last_cnt, e_last);
        check_val("tick",     bus.tick,     e_tick);
        check_val("err",      bus.err,      m_err);
        check_val("cnt_tens", bus.cnt_tens, e_cnt / 10);
        check_val("cnt_ones", bus.cnt_ones, e_cnt % 10);
    endtask

    // Called at a negedge: drive inputs, take one rising edge, compare at
    // the next negedge.
    task automatic step(input bit e, input logic [2:0] code, input bit we = 0,
                        input logic [1:0] sel = 0, input int data = 0);
        bus.en             = e;
        bus.light_cnt_init = code;
        bus.cfg_we         = we;
        bus.cfg_sel        = sel;
        bus.cfg_data       = 7'(data);
        @(posedge clk);
        cyc++;
        model_edge(e, code, we, sel, data);
        @(negedge clk);
        check_all();
        $display("cyc %0d en %0d code %b we %0d sel %0d data %0d -> cnt %0d last %0d tick %0d err %0d",
                 cyc, e, code, we, sel, data, bus.cnt, bus.last_cnt, bus.tick, bus.err);
    endtask

    // Reset asserted between edges; outputs must clear before any clock.
    task automatic do_reset();
        bus.en = 0; bus.light_cnt_init = 0; bus.cfg_we = 0; bus.cfg_sel = 0; bus.cfg_data = 0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("async_rst_cnt",  bus.cnt,      0);
        check_val("async_rst_last", bus.last_cnt, 0);
        check_val("async_rst_err",  bus.err,      0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        bus.en = 0; bus.light_cnt_init = 0; bus.cfg_we = 0; bus.cfg_sel = 0; bus.cfg_data = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_val("rst_cnt",  bus.cnt,      0);
        check_val("rst_last", bus.last_cnt, 0);
        check_val("rst_tick", bus.tick,     0);
        check_val("rst_err",  bus.err,      0);
        rst_n = 1'b1;

        // green from IDLE, yellow and red loads
        step(1, 3'b000);
        check_val("e0_cnt", bus.cnt, 15);
        repeat (56) step(1, 3'b000);
        check_val("e56_cnt", bus.cnt, 1);
        repeat (4) step(1, 3'b000);
        check_val("e60_cnt", bus.cnt, 0);
        check_val("e60_last", bus.last_cnt, 1);
        step(1, 3'b010);
        check_val("e61_cnt", bus.cnt, 3);
        check_val("e61_last", bus.last_cnt, 0);
        repeat (12) step(1, 3'b000);
        check_val("e73_last", bus.last_cnt, 1);
        step(1, 3'b001);
        check_val("red_cnt", bus.cnt, 18);
        check_val("red_tens", bus.cnt_tens, 1);
        check_val("red_ones", bus.cnt_ones, 8);

        // drop en mid-run at cnt 9, then re-raise
        n = 0;
        while (bus.cnt != 9 && n < 200) begin step(1, 3'b000); n++; end
        check_val("reach_cnt9", n < 200, 1);
        step(0, 3'b000);
        check_val("en_drop_cnt", bus.cnt, 0);
        check_val("en_drop_last", bus.last_cnt, 0);
        check_val("en_drop_tick", bus.tick, 0);
        step(1, 3'b000);
        check_val("en_raise_cnt", bus.cnt, 15);

        // multi-bit code: no reload, error
        step(1, 3'b110);
        check_val("multi_err", bus.err, 1);
        check_val("multi_cnt", bus.cnt, 15);
        // load coincident with tick
        n = 0;
        while (!bus.tick && n < 10) begin step(1, 3'b000); n++; end
        check_val("reach_tick", bus.tick, 1);
        step(1, 3'b100);
        check_val("tick_load_cnt", bus.cnt, 15);
        check_val("tick_load_tick", bus.tick, 0);
        repeat (3) step(1, 3'b000);
        check_val("tick_load_ps", bus.tick, 1);

        // duration write during green, then 20-cycle yellow
        do_reset();
        step(1, 3'b000);
        step(1, 3'b000, 1, 2'd1, 5);
        check_val("wr_green_cnt", bus.cnt, 15);
        check_val("wr_ok_err", bus.err, 0);
        n = 0;
        while (!bus.last_cnt && n < 100) begin step(1, 3'b000); n++; end
        check_val("reach_green_exp", bus.last_cnt, 1);
        step(1, 3'b010);
        check_val("y5_cnt", bus.cnt, 5);
        n = 0;
        while (!bus.last_cnt && n < 100) begin step(1, 3'b000); n++; end
        check_val("y5_len", n, 20);

        // rejected writes keep the previous value
        step(1, 3'b000, 1, 2'd1, 0);
        check_val("rej0_err", bus.err, 1);
        step(1, 3'b000, 1, 2'd1, 100);
        step(0, 3'b000);
        step(0, 3'b000);
        check_val("err_sticky", bus.err, 1);
        step(1, 3'b000);
        n = 0;
        while (!bus.last_cnt && n < 100) begin step(1, 3'b000); n++; end
        step(1, 3'b010);
        check_val("rej_keep_y", bus.cnt, 5);
        do_reset();
        step(0, 3'b000, 1, 2'd3, 7);
        check_val("rej_sel3_err", bus.err, 1);
        do_reset();
        step(0, 3'b000, 1, 2'd2, 100);
        check_val("rej100_err", bus.err, 1);
        do_reset();
        step(1, 3'b000, 1, 2'd0, 40);
        check_val("wr_same_load", bus.cnt, 15);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit e, we;
            logic [2:0] code;
            logic [1:0] sel;
            int data;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
                continue;
            end
            e    = ($urandom_range(0, 19) != 0);
            code = 3'b000;
            if (bus.last_cnt || $urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 4))
                    0: code = 3'b100;
                    1: code = 3'b010;
                    2: code = 3'b001;
                    3: code = 3'($urandom_range(0, 7));
                    default: code = 3'b000;
                endcase
            end
            we   = ($urandom_range(0, 9) == 0);
            sel  = 2'($urandom_range(0, 3));
            data = (sel == 2'd3 || $urandom_range(0, 7) == 0) ? $urandom_range(0, 110)
                                                              : $urandom_range(1, 12);
            step(e, code, we, sel, data);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
